// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: STAGES-deep with stall/flush/valid, writeback mux and HI/LO ownership.
// Optional MEMWB_OVF_TRAP_EN: signed overflow suppresses writes and raises exc_ovf.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  memtoreg_in,
  input  logic                  regwr_in,
  input  logic [DATA_W-1:0]     dout_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [REG_AW-1:0]     rw_in,
  input  logic                  overflow_in,
  input  logic                  mthi_in,
  input  logic                  mtlo_in,
  input  logic                  mult_in,
  input  logic [2*DATA_W-1:0]   mult_result_in,
  output logic                  out_valid,
  output logic                  wb_we,
  output logic [REG_AW-1:0]     wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     pc_out,
  output logic                  overflow_out,
  output logic                  exc_ovf,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  if ((STAGES < 1) || (STAGES > 4)) begin : gen_bad_stages
    $error("mem_wb_pipe: STAGES must be in 1..4");
  end

  localparam int unsigned L = STAGES - 1;

  logic [STAGES-1:0]   valid_q, memtoreg_q, regwr_q, overflow_q, mthi_q, mtlo_q, mult_q;
  logic [DATA_W-1:0]   dout_q   [STAGES];
  logic [DATA_W-1:0]   result_q [STAGES];
  logic [DATA_W-1:0]   pc_q     [STAGES];
  logic [REG_AW-1:0]   rw_q     [STAGES];
  logic [2*DATA_W-1:0] mres_q   [STAGES];
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                ovf_block;
  logic                commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      memtoreg_q <= '0;
      regwr_q    <= '0;
      overflow_q <= '0;
      mthi_q     <= '0;
      mtlo_q     <= '0;
      mult_q     <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        dout_q[k]   <= '0;
        result_q[k] <= '0;
        pc_q[k]     <= '0;
        rw_q[k]     <= '0;
        mres_q[k]   <= '0;
      end
    end else if (flush) begin
      // Payload is left stale; only the valid bits matter after a flush.
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0]    <= in_valid;
      memtoreg_q[0] <= memtoreg_in;
      regwr_q[0]    <= regwr_in;
      overflow_q[0] <= overflow_in;
      mthi_q[0]     <= mthi_in;
      mtlo_q[0]     <= mtlo_in;
      mult_q[0]     <= mult_in;
      dout_q[0]     <= dout_in;
      result_q[0]   <= result_in;
      pc_q[0]       <= pc_in;
      rw_q[0]       <= rw_in;
      mres_q[0]     <= mult_result_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_q[k]    <= valid_q[k-1];
        memtoreg_q[k] <= memtoreg_q[k-1];
        regwr_q[k]    <= regwr_q[k-1];
        overflow_q[k] <= overflow_q[k-1];
        mthi_q[k]     <= mthi_q[k-1];
        mtlo_q[k]     <= mtlo_q[k-1];
        mult_q[k]     <= mult_q[k-1];
        dout_q[k]     <= dout_q[k-1];
        result_q[k]   <= result_q[k-1];
        pc_q[k]       <= pc_q[k-1];
        rw_q[k]       <= rw_q[k-1];
        mres_q[k]     <= mres_q[k-1];
      end
    end
  end

`ifdef MEMWB_OVF_TRAP_EN
  assign ovf_block = overflow_q[L];
  assign exc_ovf   = valid_q[L] & overflow_q[L] & ~stall;
`else
  assign ovf_block = 1'b0;
  assign exc_ovf   = 1'b0;
`endif

  // Commit is independent of flush: the last stage's commit belongs to this cycle.
  assign commit = valid_q[L] & ~stall & ~ovf_block;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (mult_q[L]) begin
        hi_q <= mres_q[L][2*DATA_W-1:DATA_W];
        lo_q <= mres_q[L][DATA_W-1:0];
      end else begin
        if (mthi_q[L]) hi_q <= result_q[L];
        if (mtlo_q[L]) lo_q <= result_q[L];
      end
    end
  end

  always_comb begin
    out_valid    = valid_q[L];
    wb_we        = valid_q[L] & regwr_q[L] & ~stall & (rw_q[L] != '0) & ~ovf_block;
    wb_addr      = rw_q[L];
    wb_data      = memtoreg_q[L] ? dout_q[L] : result_q[L];
    pc_out       = pc_q[L];
    overflow_out = overflow_q[L] & valid_q[L];
    hi           = hi_q;
    lo           = lo_q;
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (STAGES=3): queue-based model checked every cycle plus literal pins.
module tb_mem_wb_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ST = 3;
`ifdef MEMWB_OVF_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, in_valid, memtoreg_in, regwr_in;
  logic [DW-1:0] dout_in, result_in, pc_in;
  logic [AW-1:0] rw_in;
  logic          overflow_in, mthi_in, mtlo_in, mult_in;
  logic [2*DW-1:0] mult_result_in;
  logic          out_valid, wb_we, overflow_out, exc_ovf;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data, pc_out, hi, lo;

  mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .memtoreg_in(memtoreg_in), .regwr_in(regwr_in), .dout_in(dout_in),
    .result_in(result_in), .pc_in(pc_in), .rw_in(rw_in), .overflow_in(overflow_in),
    .mthi_in(mthi_in), .mtlo_in(mtlo_in), .mult_in(mult_in),
    .mult_result_in(mult_result_in), .out_valid(out_valid), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .pc_out(pc_out), .overflow_out(overflow_out),
    .exc_ovf(exc_ovf), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of in-flight instructions, newest at index 0, oldest (writeback) at ST-1.
  typedef struct {
    logic v, m2r, wen, ovf, mthi, mtlo, mult;
    logic [31:0] dout, res, pc;
    logic [4:0]  rw;
    logic [63:0] mres;
  } ent_t;

  ent_t pipe[$];
  logic [31:0] mhi, mlo;

  function automatic ent_t zero_ent();
    ent_t e;
    e.v = 0; e.m2r = 0; e.wen = 0; e.ovf = 0; e.mthi = 0; e.mtlo = 0; e.mult = 0;
    e.dout = 0; e.res = 0; e.pc = 0; e.rw = 0; e.mres = 0;
    return e;
  endfunction

  initial begin
    for (int k = 0; k < ST; k++) pipe.push_back(zero_ent());
    mhi = 0;
    mlo = 0;
  end

  always @(posedge clk) begin
    ent_t l, n;
    l = pipe[ST-1];
    if (!rst_n) begin
      for (int k = 0; k < ST; k++) pipe[k] = zero_ent();
      mhi = 0;
      mlo = 0;
    end else begin
      if (l.v && !stall && !(Trap && l.ovf)) begin
        if (l.mult) begin
          mhi = l.mres[63:32];
          mlo = l.mres[31:0];
        end else begin
          if (l.mthi) mhi = l.res;
          if (l.mtlo) mlo = l.res;
        end
      end
      if (flush) begin
        for (int k = 0; k < ST; k++) begin
          n = pipe[k];
          n.v = 0;
          pipe[k] = n;
        end
      end else if (!stall) begin
        n.v = in_valid; n.m2r = memtoreg_in; n.wen = regwr_in; n.ovf = overflow_in;
        n.mthi = mthi_in; n.mtlo = mtlo_in; n.mult = mult_in;
        n.dout = dout_in; n.res = result_in; n.pc = pc_in; n.rw = rw_in;
        n.mres = mult_result_in;
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    ent_t l;
    if (chk_en) begin
      l = pipe[ST-1];
      chk("m_out_valid", out_valid, l.v);
      chk("m_wb_we", wb_we, l.v & l.wen & !stall & (l.rw != 0) & !(Trap & l.ovf));
      chk("m_overflow_out", overflow_out, l.v & l.ovf);
      chk("m_exc_ovf", exc_ovf, Trap & l.v & l.ovf & !stall);
      chk("m_hi", hi, mhi);
      chk("m_lo", lo, mlo);
      if (l.v) begin
        chk("m_wb_addr", wb_addr, l.rw);
        chk("m_wb_data", wb_data, l.m2r ? l.dout : l.res);
        chk("m_pc_out", pc_out, l.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; flush = 0; in_valid = 0; memtoreg_in = 0; regwr_in = 0;
    dout_in = 0; result_in = 0; pc_in = 0; rw_in = 0; overflow_in = 0;
    mthi_in = 0; mtlo_in = 0; mult_in = 0; mult_result_in = 0;
  endtask

  task automatic rnd_inputs();
    in_valid = 1'($urandom); memtoreg_in = 1'($urandom); regwr_in = 1'($urandom);
    dout_in = $urandom; result_in = $urandom; pc_in = $urandom; rw_in = 5'($urandom);
    overflow_in = 1'($urandom); mthi_in = 1'($urandom); mtlo_in = 1'($urandom);
    mult_in = 1'($urandom); mult_result_in = {$urandom, $urandom};
  endtask

  // Push one instruction then return inputs to idle after the latching edge.
  task automatic issue(input logic m2r, input logic [4:0] rw, input logic [31:0] dout,
                       input logic [31:0] res, input logic ovf, input logic th,
                       input logic tl, input logic mu, input logic [63:0] mres);
    idle();
    in_valid = 1; regwr_in = 1; memtoreg_in = m2r; rw_in = rw; dout_in = dout;
    result_in = res; pc_in = 32'h0040_0000 + {27'd0, rw}; overflow_in = ovf;
    mthi_in = th; mtlo_in = tl; mult_in = mu; mult_result_in = mres;
    step();
    idle();
  endtask

  initial begin
    // Reset with random inputs and stall held high
    rst_n = 0;
    stall = 1;
    flush = 0;
    repeat (2) begin
      rnd_inputs();
      step();
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_overflow_out", overflow_out, 0);
    chk("rst_exc_ovf", exc_ovf, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    idle();
    rst_n = 1;
    chk_en = 1;
    step();

    // lw reaches writeback exactly ST cycles later, for one cycle
    issue(1'b1, 5'd8, 32'hDEAD_BEEF, 32'h1234, 0, 0, 0, 0, 64'd0);
    step();
    chk("lw_early_we", wb_we, 0);
    step();
    chk("lw_we", wb_we, 1);
    chk("lw_addr", wb_addr, 8);
    chk("lw_data", wb_data, 32'hDEAD_BEEF);
    step();
    chk("lw_after_we", wb_we, 0);

    // Stall with instruction in the last stage: single write pulse after release
    issue(1'b0, 5'd5, 32'h0, 32'hAA, 0, 0, 0, 0, 64'd0);
    step();
    step();
    stall = 1;
    #1;
    chk("stall_we0", wb_we, 0);
    step();
    chk("stall_we1", wb_we, 0);
    chk("stall_valid", out_valid, 1);
    step();
    chk("stall_we2", wb_we, 0);
    stall = 0;
    #1;
    chk("release_we", wb_we, 1);
    chk("release_data", wb_data, 32'hAA);
    step();
    chk("release_after_we", wb_we, 0);

    // $0 is never written
    issue(1'b0, 5'd0, 32'h0, 32'h77, 0, 0, 0, 0, 64'd0);
    step();
    step();
    chk("r0_valid", out_valid, 1);
    chk("r0_we", wb_we, 0);
    step();

    // Flush+stall with two valid instructions in flight
    issue(1'b0, 5'd3, 32'h0, 32'h99, 0, 1, 0, 0, 64'd0);
    issue(1'b0, 5'd4, 32'h0, 32'h98, 0, 0, 1, 0, 64'd0);
    flush = 1;
    stall = 1;
    step();
    idle();
    chk("flush_valid", out_valid, 0);
    repeat (3) begin
      step();
      chk("flush_we", wb_we, 0);
      chk("flush_valid_later", out_valid, 0);
    end
    chk("flush_hi", hi, 0);
    chk("flush_lo", lo, 0);

    // HI/LO: mult, then mthi+mtlo, then mult beats mthi
    issue(1'b0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 1, 64'h0000_0001_8000_0000);
    repeat (3) step();
    chk("mult_hi", hi, 32'h1);
    chk("mult_lo", lo, 32'h8000_0000);
    issue(1'b0, 5'd0, 32'h0, 32'h55, 0, 1, 1, 0, 64'd0);
    repeat (3) step();
    chk("mthilo_hi", hi, 32'h55);
    chk("mthilo_lo", lo, 32'h55);
    issue(1'b0, 5'd0, 32'h0, 32'h77, 0, 1, 0, 1, 64'h1234_5678_9ABC_DEF0);
    repeat (3) step();
    chk("multwin_hi", hi, 32'h1234_5678);
    chk("multwin_lo", lo, 32'h9ABC_DEF0);

    // Overflow: trap build suppresses writes, otherwise only flagged
    issue(1'b0, 5'd9, 32'h0, 32'h11, 1, 1, 0, 0, 64'd0);
    step();
    step();
    chk("ovf_we", wb_we, !Trap);
    chk("ovf_exc", exc_ovf, Trap);
    chk("ovf_flag", overflow_out, 1);
    step();
    chk("ovf_hi", hi, Trap ? 32'h1234_5678 : 32'h11);

    // Directed mixed stream, checked cycle by cycle against the model
    for (int i = 0; i < 48; i++) begin
      in_valid = (i % 3) != 2;
      regwr_in = (i % 4) != 3;
      memtoreg_in = (i % 2) == 1;
      rw_in = 5'(i);
      dout_in = 32'h0101_0101 * i;
      result_in = 32'hF00D_0000 + i;
      pc_in = 32'h0040_0100 + 4 * i;
      overflow_in = (i % 8) == 6;
      mthi_in = (i % 5) == 1;
      mtlo_in = (i % 6) == 2;
      mult_in = (i % 9) == 4;
      mult_result_in = {32'hA000_0000 + i, 32'h0B00_0000 + i};
      stall = (i % 7) == 3;
      flush = (i % 11) == 5;
      step();
    end
    idle();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
